// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaled SHIFT / BOUNCE / FLASH patterns gated by a one-hot colour select.
// Define LED_SEQ_BTN_SYNC_EN to put a 2-FF synchroniser on each button before edge detection.
module led_seq_ctrl #(
    parameter int          N_LEDS = 4,
    parameter int          NB_CNT = 32,
    parameter int unsigned LIM0   = 2**23,
    parameter int unsigned LIM1   = 2**24,
    parameter int unsigned LIM2   = 2**25,
    parameter int unsigned LIM3   = 2**26
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [3:0]        i_sw,
    input  logic [3:0]        i_btn,
    output logic [N_LEDS-1:0] o_led_r,
    output logic [N_LEDS-1:0] o_led_g,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [1:0]        o_mode,
    output logic              o_tick
);

    typedef enum logic [1:0] {
        MODE_SHIFT   = 2'b00,
        MODE_BOUNCE  = 2'b01,
        MODE_FLASH   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    localparam logic [N_LEDS-1:0] PAT_ONE = N_LEDS'(1);

    mode_e              mode_q, mode_d, mode_step;
    logic [N_LEDS-1:0]  pat_q, pat_d;
    logic               dir_q, dir_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [2:0]         color_q, color_d;
    logic [N_LEDS-1:0]  led_r_q, led_g_q, led_b_q;
    logic               armed_q;
    logic [3:0]         btn_prev_q;
    logic [3:0]         btn_lvl;
    logic [3:0]         btn_edge;
    logic [NB_CNT-1:0]  lim_sel, lim_m1;
    logic               adv;

    // The first clock after reset loads the button history straight from the pins,
    // so a button held through reset release never produces an edge.
`ifdef LED_SEQ_BTN_SYNC_EN
    logic [3:0] btn_s1_q, btn_s2_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            btn_s1_q <= i_btn;
            btn_s2_q <= armed_q ? btn_s1_q : i_btn;
        end
    end

    assign btn_lvl = btn_s2_q;
`else
    assign btn_lvl = i_btn;
`endif

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            armed_q    <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            armed_q    <= 1'b1;
            btn_prev_q <= armed_q ? btn_lvl : i_btn;
        end
    end

    assign btn_edge = {4{armed_q}} & btn_lvl & ~btn_prev_q;

    always_comb begin
        case (i_sw[2:1])
            2'd0:    lim_sel = NB_CNT'(LIM0);
            2'd1:    lim_sel = NB_CNT'(LIM1);
            2'd2:    lim_sel = NB_CNT'(LIM2);
            default: lim_sel = NB_CNT'(LIM3);
        endcase
    end

    assign lim_m1 = lim_sel - NB_CNT'(1);
    // >= rather than == so a switch to a faster speed fires immediately instead of wrapping.
    assign adv    = i_sw[0] && (cnt_q >= lim_m1);

    always_comb begin
        case (mode_q)
            MODE_SHIFT:  mode_step = MODE_BOUNCE;
            MODE_BOUNCE: mode_step = MODE_FLASH;
            default:     mode_step = MODE_SHIFT;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        color_d = color_q;
        cnt_d   = '0;

        if (i_sw[0] && !adv) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end

        if (mode_q == MODE_ILLEGAL) begin
            mode_d = MODE_SHIFT;
            pat_d  = PAT_ONE;
            dir_d  = 1'b0;
            cnt_d  = '0;
        end else if (btn_edge[0]) begin
            mode_d = mode_step;
            pat_d  = (mode_step == MODE_FLASH) ? '0 : PAT_ONE;
            dir_d  = 1'b0;
            cnt_d  = '0;
        end else if (adv) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_SHIFT: begin
                    if (i_sw[3]) pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
                    else         pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
                end
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (pat_q[N_LEDS-1]) begin
                            pat_d = pat_q >> 1;
                            dir_d = 1'b1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            pat_d = pat_q << 1;
                            dir_d = 1'b0;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                default: pat_d = ~pat_q;
            endcase
        end

        // Highest-priority pressed colour wins; re-selecting the current colour is a no-op.
        if (btn_edge[1]) begin
            if (!color_q[0]) color_d = 3'b001;
        end else if (btn_edge[2]) begin
            if (!color_q[1]) color_d = 3'b010;
        end else if (btn_edge[3]) begin
            if (!color_q[2]) color_d = 3'b100;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q  <= MODE_SHIFT;
            pat_q   <= PAT_ONE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            color_q <= 3'b001;
            led_r_q <= PAT_ONE;
            led_g_q <= '0;
            led_b_q <= '0;
        end else begin
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            color_q <= color_d;
            led_r_q <= pat_d & {N_LEDS{color_d[0]}};
            led_g_q <= pat_d & {N_LEDS{color_d[1]}};
            led_b_q <= pat_d & {N_LEDS{color_d[2]}};
        end
    end

    assign o_led_r = led_r_q;
    assign o_led_g = led_g_q;
    assign o_led_b = led_b_q;
    assign o_mode  = mode_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short prescaler periods (LIM0=4, LIM3=200).
module tb_led_seq_ctrl;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic [3:0] i_btn;
    logic [3:0] o_led_r, o_led_g, o_led_b;
    logic [1:0] o_mode;
    logic       o_tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_seq_ctrl #(
        .N_LEDS(4), .NB_CNT(32),
        .LIM0(4), .LIM1(8), .LIM2(16), .LIM3(200)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .i_btn   (i_btn),
        .o_led_r (o_led_r),
        .o_led_g (o_led_g),
        .o_led_b (o_led_b),
        .o_mode  (o_mode),
        .o_tick  (o_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("  ok %s = %0h", tag, obs);
        end
    endtask

    // One full LIM0 period: quiet for three cycles, then tick with the new pattern.
    task automatic run_tick(input string tag, input logic [3:0] exp_r);
        repeat (3) @(negedge clock);
        check({tag, "_idle"}, 32'(o_tick), 32'd0);
        @(negedge clock);
        check({tag, "_tick"}, 32'(o_tick), 32'd1);
        check({tag, "_led"}, 32'(o_led_r), 32'(exp_r));
    endtask

    task automatic press(input logic [3:0] b);
        i_btn = b;
        @(negedge clock);
        i_btn = 4'b0000;
    endtask

    initial begin
        i_reset = 1'b1;
        i_sw    = 4'b0000;
        i_btn   = 4'b0000;
        #2 i_reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_led_r", 32'(o_led_r), 32'h1);
        check("rst_led_g", 32'(o_led_g), 32'h0);
        check("rst_led_b", 32'(o_led_b), 32'h0);
        check("rst_mode",  32'(o_mode),  32'h0);
        check("rst_tick",  32'(o_tick),  32'h0);

        // SHIFT toward MSB
        i_sw    = 4'b0001;
        i_reset = 1'b1;
        run_tick("shl1", 4'b0010);
        run_tick("shl2", 4'b0100);
        run_tick("shl3", 4'b1000);
        run_tick("shl4", 4'b0001);

        // SHIFT toward LSB
        i_sw = 4'b1001;
        run_tick("shr1", 4'b1000);
        run_tick("shr2", 4'b0100);

        // BOUNCE ignores i_sw[3]
        press(4'b0001);
        check("bnc_mode", 32'(o_mode),  32'h1);
        check("bnc_init", 32'(o_led_r), 32'h1);
        check("bnc_tick0", 32'(o_tick), 32'h0);
        run_tick("bnc1", 4'b0010);
        run_tick("bnc2", 4'b0100);
        run_tick("bnc3", 4'b1000);
        run_tick("bnc4", 4'b0100);
        run_tick("bnc5", 4'b0010);
        run_tick("bnc6", 4'b0001);

        // FLASH, then back to SHIFT
        press(4'b0001);
        check("fl_mode", 32'(o_mode),  32'h2);
        check("fl_init", 32'(o_led_r), 32'h0);
        run_tick("fl1", 4'b1111);
        run_tick("fl2", 4'b0000);
        run_tick("fl3", 4'b1111);
        press(4'b0001);
        check("sh_mode", 32'(o_mode),  32'h0);
        check("sh_init", 32'(o_led_r), 32'h1);

        // Mode step on the same edge as a tick
        repeat (3) @(negedge clock);
        press(4'b0001);
        check("coll_mode", 32'(o_mode),  32'h1);
        check("coll_led",  32'(o_led_r), 32'h1);
        check("coll_tick", 32'(o_tick),  32'h0);
        run_tick("restart", 4'b0010);

        // Run disabled: frozen pattern, no ticks
        i_sw = 4'b1000;
        repeat (6) @(negedge clock);
        check("frz_tick", 32'(o_tick),  32'h0);
        check("frz_led",  32'(o_led_r), 32'h2);

        // Green and blue together, held: green only
        i_btn = 4'b1100;
        repeat (10) @(negedge clock);
        i_btn = 4'b0000;
        check("gb_led_g", 32'(o_led_g), 32'h2);
        check("gb_led_r", 32'(o_led_r), 32'h0);
        check("gb_led_b", 32'(o_led_b), 32'h0);
        @(negedge clock);
        press(4'b1000);
        check("blu_led_b", 32'(o_led_b), 32'h2);
        check("blu_led_g", 32'(o_led_g), 32'h0);
        press(4'b0010);
        check("red_led_r", 32'(o_led_r), 32'h2);
        check("red_led_b", 32'(o_led_b), 32'h0);

        // Slow speed to count 100, then switch to speed 0
        i_sw = 4'b0111;
        repeat (100) @(negedge clock);
        check("slow_tick", 32'(o_tick), 32'h0);
        i_sw = 4'b0001;
        @(negedge clock);
        check("spd_tick", 32'(o_tick),  32'h1);
        check("spd_led",  32'(o_led_r), 32'h4);
        run_tick("spd0", 4'b1000);

        // Asynchronous reset between clock edges
        #2 i_reset = 1'b0;
        #1;
        check("arst_led_r", 32'(o_led_r), 32'h1);
        check("arst_led_g", 32'(o_led_g), 32'h0);
        check("arst_led_b", 32'(o_led_b), 32'h0);
        check("arst_mode",  32'(o_mode),  32'h0);
        check("arst_tick",  32'(o_tick),  32'h0);

        // Button held through reset release must not step the mode
        i_btn = 4'b0001;
        @(negedge clock);
        i_reset = 1'b1;
        repeat (4) @(negedge clock);
        check("held_mode", 32'(o_mode), 32'h0);
        i_btn = 4'b0000;
        @(negedge clock);
        press(4'b0001);
        check("repress_mode", 32'(o_mode), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
